traffic_phase_scheduler: RTL and testbench

- Sequences the shared intersection for three requesters: road 1, road 2 and a pedestrian crossing.
- Latches sensor requests and grants phases round-robin.
- Enforces minimum/maximum green, yellow and all-red clearance times, and supports emergency-vehicle preemption.
- Sits between the sensor/emergency inputs on the IO pads and the lamp-driver pads, in place of a fixed-cycle controller inside `user_project_wrapper`.

---
 rtl/traffic_phase_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
// Sequences a shared intersection between road 1, road 2 and a pedestrian
// crossing. Requests are latched and served round-robin. The scheduler
// enforces minimum/maximum green, yellow, all-red clearance and walk times,
// and supports emergency-vehicle preemption of either road.
//
// Ports:
//   clk         single clock
//   rst_n       synchronous active-low reset
//   enable      run when high, forces IDLE (all red) when low
//   req[2:0]    requests: bit0 road 1, bit1 road 2, bit2 pedestrian
//   emerg       emergency preemption (level)
//   emerg_road  preempting road: 0 = road 1, 1 = road 2
//   road1_out   road 1 lamps {red, yellow, green}
//   road2_out   road 2 lamps {red, yellow, green}
//   walk_out    pedestrian walk lamp
//   grant[2:0]  one-hot phase owner, 0 when no owner
//   io_oeb[6:0] pad output enables, active-low
module traffic_phase_scheduler #(
  parameter int CNT_W     = 16,
  parameter int MIN_GREEN = 16,
  parameter int MAX_GREEN = 64,
  parameter int YELLOW    = 8,
  parameter int ALL_RED   = 4,
  parameter int WALK      = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] req,
  input  logic       emerg,
  input  logic       emerg_road,
  output logic [2:0] road1_out,
  output logic [2:0] road2_out,
  output logic       walk_out,
  output logic [2:0] grant,
  output logic [6:0] io_oeb
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GREEN,
    ST_YELLOW,
    ST_CLEAR,
    ST_WALK
  } state_t;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  // Timer holds (cycles spent - 1), so a phase of N cycles ends on the edge
  // where the timer reads N-1.
  localparam logic [CNT_W-1:0] MIN_T   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_T   = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] CLR_T   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] WALK_T  = CNT_W'(WALK - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT = {CNT_W{1'b1}};

  state_t           state_reg, state_next;
  logic [1:0]       owner_reg, owner_next;   // 0 road 1, 1 road 2, 2 pedestrian
  logic [1:0]       last_reg, last_next;
  logic [2:0]       pend_reg, pend_next;
  logic [CNT_W-1:0] timer_reg, timer_next;

  logic [2:0] road1_reg, road2_reg, grant_reg;
  logic       walk_reg;
  logic [6:0] oeb_reg;

  logic [2:0] req_keep;
  logic [2:0] cand;
  logic [2:0] others;
  logic [2:0] grant_clear;
  logic [1:0] winner;
  logic       arbitrate;

  // Round-robin pick: first set bit scanning from last+1 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] c, input logic [1:0] l);
    logic [1:0] pick;
    int         idx;
    pick = 2'd0;
    // Scan in reverse so the nearest set bit is the one left standing.
    for (int k = 3; k >= 1; k--) begin
      idx = (int'(l) + k) % 3;
      if (c[idx]) pick = 2'(idx);
    end
    return pick;
  endfunction

  function automatic logic [2:0] one_hot(input logic [1:0] idx);
    return (idx == 2'd3) ? 3'b000 : (3'b001 << idx);
  endfunction

  function automatic logic [2:0] lamp(input state_t st, input logic [1:0] own,
                                      input logic [1:0] road);
    logic [2:0] l;
    l = LAMP_RED;
    if (own == road) begin
      if (st == ST_GREEN)  l = LAMP_GRN;
      if (st == ST_YELLOW) l = LAMP_YEL;
    end
    return l;
  endfunction

  // A requester's own request is ignored while it holds GREEN or WALK, so a
  // held level does not queue a second service behind itself.
  for (genvar gi = 0; gi < 3; gi++) begin : g_keep
    assign req_keep[gi] = req[gi] &
        ~((state_reg == ST_GREEN && owner_reg == 2'(gi)) ||
          (state_reg == ST_WALK  && gi == 2));
  end

  assign cand   = pend_reg | req;
  assign others = cand & ~one_hot(owner_reg);
  assign winner = emerg ? {1'b0, emerg_road} : rr_pick(cand, last_reg);

  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    last_next   = last_reg;
    grant_clear = 3'b000;
    arbitrate   = 1'b0;

    case (state_reg)
      ST_IDLE: arbitrate = 1'b1;
      ST_GREEN: begin
        if (emerg) begin
          // Preempting road keeps green; the other road yields at once.
          if (owner_reg != {1'b0, emerg_road}) state_next = ST_YELLOW;
        end else if (|others &&
                     ((timer_reg >= MIN_T && !req[owner_reg]) || timer_reg >= MAX_T)) begin
          state_next = ST_YELLOW;
        end
      end
      ST_YELLOW: if (timer_reg == YEL_T) state_next = ST_CLEAR;
      ST_CLEAR:  if (timer_reg == CLR_T) arbitrate = 1'b1;
      ST_WALK:   if (emerg || timer_reg == WALK_T) state_next = ST_CLEAR;
      default:   state_next = ST_IDLE;
    endcase

    if (arbitrate) begin
      if (emerg || |cand) begin
        state_next  = (winner == 2'd2) ? ST_WALK : ST_GREEN;
        owner_next  = winner;
        last_next   = winner;
        grant_clear = one_hot(winner);
      end else begin
        state_next = ST_IDLE;
      end
    end

    pend_next = (pend_reg | req_keep) & ~grant_clear;

    if (!enable) begin
      state_next = ST_IDLE;
      owner_next = owner_reg;
      last_next  = last_reg;
      pend_next  = pend_reg;
    end

    // Restart on every state entry; IDLE keeps the timer at zero.
    if (state_next != state_reg || state_next == ST_IDLE)
      timer_next = '0;
    else if (timer_reg != TIMER_SAT)
      timer_next = timer_reg + 1'b1;
    else
      timer_next = timer_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      owner_reg <= 2'd0;
      last_reg  <= 2'd2;
      pend_reg  <= 3'b000;
      timer_reg <= '0;
      road1_reg <= LAMP_RED;
      road2_reg <= LAMP_RED;
      walk_reg  <= 1'b0;
      grant_reg <= 3'b000;
      oeb_reg   <= 7'h7F;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      pend_reg  <= pend_next;
      timer_reg <= timer_next;
      // Lamps are decoded from the next state so they line up with it.
      road1_reg <= lamp(state_next, owner_next, 2'd0);
      road2_reg <= lamp(state_next, owner_next, 2'd1);
      walk_reg  <= (state_next == ST_WALK);
      grant_reg <= (state_next == ST_GREEN || state_next == ST_YELLOW ||
                    state_next == ST_WALK) ? one_hot(owner_next) : 3'b000;
      oeb_reg   <= 7'h00;
    end
  end

  assign road1_out = road1_reg;
  assign road2_out = road2_reg;
  assign walk_out  = walk_reg;
  assign grant     = grant_reg;
  assign io_oeb    = oeb_reg;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: a table of single-cycle vectors
// followed by hand-written multi-cycle sequences that measure phase lengths.
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, enable, emerg, emerg_road;
  logic [2:0] req;
  logic [2:0] road1_out, road2_out, grant;
  logic       walk_out;
  logic [6:0] io_oeb;

  int n_vec = 0;
  int n_bad = 0;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req        (req),
    .emerg      (emerg),
    .emerg_road (emerg_road),
    .road1_out  (road1_out),
    .road2_out  (road2_out),
    .walk_out   (walk_out),
    .grant      (grant),
    .io_oeb     (io_oeb)
  );

  always #5 clk = ~clk;

  // Output bundle {road1, road2, walk, grant, io_oeb}
  localparam logic [16:0] RST  = {3'b100, 3'b100, 1'b0, 3'b000, 7'h7F};
  localparam logic [16:0] ALLR = {3'b100, 3'b100, 1'b0, 3'b000, 7'h00};
  localparam logic [16:0] R1G  = {3'b001, 3'b100, 1'b0, 3'b001, 7'h00};
  localparam logic [16:0] R1Y  = {3'b010, 3'b100, 1'b0, 3'b001, 7'h00};
  localparam logic [16:0] R2G  = {3'b100, 3'b001, 1'b0, 3'b010, 7'h00};
  localparam logic [16:0] WLK  = {3'b100, 3'b100, 1'b1, 3'b100, 7'h00};

  typedef struct {
    logic        rst_n;
    logic        enable;
    logic [2:0]  req;
    logic        emerg;
    logic        eroad;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic logic [16:0] outs();
    return {road1_out, road2_out, walk_out, grant, io_oeb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  // Counts consecutive cycles (including the current one) showing pat.
  task automatic count_hold(input logic [16:0] pat, input int limit, output int n);
    n = 0;
    while (outs() == pat && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic do_reset();
    req = 3'b000; emerg = 1'b0; emerg_road = 1'b0; enable = 1'b1;
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    //          rst_n enable req     emerg eroad exp
    tbl[0]  = '{1'b0, 1'b0, 3'b000, 1'b0, 1'b0, RST };  // reset state
    tbl[1]  = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, RST };
    tbl[2]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, ALLR};  // io_oeb drops
    tbl[3]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, ALLR};  // idle, no request
    tbl[4]  = '{1'b1, 1'b1, 3'b001, 1'b0, 1'b0, R1G };  // road 1 granted next edge
    tbl[5]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, R1G };
    tbl[6]  = '{1'b1, 1'b1, 3'b001, 1'b0, 1'b0, R1G };  // own req ignored
    tbl[7]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0, ALLR};  // disable -> idle
    tbl[8]  = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, ALLR};  // nothing was pending
    tbl[9]  = '{1'b1, 1'b1, 3'b001, 1'b0, 1'b0, R1G };
    tbl[10] = '{1'b1, 1'b1, 3'b000, 1'b1, 1'b0, R1G };  // preempting road holds
    tbl[11] = '{1'b1, 1'b1, 3'b000, 1'b1, 1'b0, R1G };
    tbl[12] = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, R1G };  // rests in green
    tbl[13] = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, RST };  // reset mid-green
    tbl[14] = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, ALLR};
    tbl[15] = '{1'b1, 1'b1, 3'b000, 1'b1, 1'b1, R2G };  // emergency from idle
    tbl[16] = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, R2G };
    tbl[17] = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b0, RST };
    tbl[18] = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b0, ALLR};

    rst_n = 1'b0; enable = 1'b0; req = 3'b000; emerg = 1'b0; emerg_road = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) begin
      rst_n      = tbl[i].rst_n;
      enable     = tbl[i].enable;
      req        = tbl[i].req;
      emerg      = tbl[i].emerg;
      emerg_road = tbl[i].eroad;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
    end

    // Basic road 1: green held 200 cycles with no other requests.
    do_reset();
    req = 3'b001; tick(); req = 3'b000;
    chk("basic_grant", 32'(outs()), 32'(R1G));
    count_hold(R1G, 200, n);
    chk("basic_hold200", n, 200);

    // Gap-out: road 2 requests at t=2, road 1 quiet.
    do_reset();
    req = 3'b001; tick(); req = 3'b000;
    tick(); tick();
    req = 3'b010; tick(); req = 3'b000;
    count_hold(R1G, 200, n);
    chk("gap_green_len", n + 3, 16);
    count_hold(R1Y, 50, n);
    chk("gap_yellow_len", n, 8);
    count_hold(ALLR, 50, n);
    chk("gap_clear_len", n, 4);
    chk("gap_road2_grant", 32'(outs()), 32'(R2G));

    // Max-out: road 1 keeps requesting.
    do_reset();
    req = 3'b001; tick();
    tick(); tick();
    req = 3'b011; tick(); req = 3'b001;
    count_hold(R1G, 200, n);
    chk("max_green_len", n + 3, 64);
    count_hold(R1Y, 50, n);
    chk("max_yellow_len", n, 8);

    // Round-robin with pedestrian.
    do_reset();
    req = 3'b111; tick(); req = 3'b000;
    chk("rr_first_road1", 32'(outs()), 32'(R1G));
    count_hold(R1G, 200, n);
    chk("rr_road1_len", n, 16);
    count_hold(R1Y, 50, n);
    chk("rr_road1_yel", n, 8);
    count_hold(ALLR, 50, n);
    chk("rr_clear1", n, 4);
    chk("rr_second_road2", 32'(outs()), 32'(R2G));
    count_hold(R2G, 200, n);
    chk("rr_road2_len", n, 16);
    count_hold({3'b100, 3'b010, 1'b0, 3'b010, 7'h00}, 50, n);
    count_hold(ALLR, 50, n);
    chk("rr_third_walk", 32'(outs()), 32'(WLK));
    count_hold(WLK, 200, n);
    chk("rr_walk_len", n, 32);
    chk("rr_walk_no_yellow", 32'(outs()), 32'(ALLR));
    req = 3'b001;
    count_hold(ALLR, 50, n);
    chk("rr_walk_clear", n, 4);
    chk("rr_wrap_road1", 32'(outs()), 32'(R1G));
    req = 3'b000;

    // Preemption by road 2 while road 1 is green at t=3.
    do_reset();
    req = 3'b001; tick(); req = 3'b000;
    tick(); tick(); tick();
    emerg = 1'b1; emerg_road = 1'b1; tick();
    chk("pre_yellow_now", 32'(outs()), 32'(R1Y));
    count_hold(R1Y, 50, n);
    chk("pre_yellow_len", n, 8);
    count_hold(ALLR, 50, n);
    chk("pre_clear_len", n, 4);
    chk("pre_road2_grant", 32'(outs()), 32'(R2G));
    req = 3'b001;
    count_hold(R2G, 100, n);
    chk("pre_road2_hold", n, 100);
    emerg = 1'b0; req = 3'b000;

    // Enable dropped during yellow, pend retained.
    do_reset();
    req = 3'b001; tick();
    req = 3'b010; tick(); req = 3'b000;
    count_hold(R1G, 200, n);
    tick(); tick();
    chk("en_in_yellow", 32'(outs()), 32'(R1Y));
    enable = 1'b0; tick();
    chk("en_off_allred", 32'(outs()), 32'(ALLR));
    enable = 1'b1; tick();
    chk("en_pend_kept", 32'(outs()), 32'(R2G));

    // Reset during WALK.
    do_reset();
    req = 3'b100; tick(); req = 3'b000;
    chk("rst_walk_on", 32'(outs()), 32'(WLK));
    tick(); tick(); tick();
    rst_n = 1'b0; tick();
    chk("rst_in_walk", 32'(outs()), 32'(RST));
    rst_n = 1'b1; tick();
    chk("rst_release", 32'(outs()), 32'(ALLR));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
